ahb_master_initiator: RTL and testbench
=======================================

// Module: ahb_master_initiator
// PURPOSE
//  AHB-Lite master that drives the AHB side of the AHB-to-APB bridge: it converts a
//  simple command (addr, dir, length) into pipelined NONSEQ/SEQ transfers. Serves as
//  the bus initiator for the system bench and for on-chip DMA-style register loads.
//  Handles address/data phase overlap, wait states, 1KB boundaries and ERROR aborts.
// PARAMETERS
//  ADDR_W  32  address width (Haddr, cmd_addr)
//  DATA_W  32  data width (Hwdata, Hrdata, wr_data, rd_data)
//  LEN_W   4   width of cmd_len; burst = cmd_len+1 beats (1..16)
// PORTS
//  clk            in   1       clock, all logic on rising edge
//  rst            in   1       reset, synchronous, active-low
//  cmd_valid      in   1       command request
//  cmd_ready      out  1       high only in IDLE; accept when cmd_valid&cmd_ready
//  cmd_write      in   1       1=write burst, 0=read burst
//  cmd_addr       in   ADDR_W  start address, word aligned
//  cmd_len        in   LEN_W   beats-1
//  wr_data        in   DATA_W  next write beat; must be valid whenever wr_data_ready=1
//  wr_data_ready  out  1       pulse: wr_data consumed this edge
//  rd_data        out  DATA_W  captured read beat
//  rd_valid       out  1       1-cycle pulse per completed read beat
//  done           out  1       1-cycle pulse when burst completes or aborts
//  err            out  1       valid with done; 1 = ERROR response seen
//  Haddr          out  ADDR_W  AHB address (registered)
//  Htrans         out  2       IDLE=00, NONSEQ=10, SEQ=11 (BUSY never issued)
//  Hwrite         out  1       AHB direction
//  Hsize          out  3       constant 3'b010 (word)
//  Hburst         out  3       SINGLE 000 if cmd_len=0, else INCR 001
//  Hwdata         out  DATA_W  write data, one cycle behind its address phase
//  Hreadyout      in   1       slave ready; 0 = wait state
//  Hrdata         in   DATA_W  read data
//  Hresp          in   2       00 OKAY, 01 ERROR
// BEHAVIOUR
//  - Reset (rst=0 at edge): state IDLE; Htrans=00, Haddr=0, Hwrite=0, Hburst=0, Hwdata=0,
//    rd_data=0, rd_valid=0, done=0, err=0, wr_data_ready=0, beat counters 0. Mid-burst
//    reset aborts immediately with no done pulse; cmd_ready=1 in first cycle after release.
//  - States: IDLE -> ADDR (first NONSEQ, no data phase pending) -> BURST (SEQ/NONSEQ addr
//    phase overlapping previous data phase) -> LAST (final data phase, Htrans=IDLE) -> IDLE.
//    len=0: ADDR -> LAST directly.
//  - Accept edge: Haddr<=cmd_addr, Htrans<=NONSEQ, Hwrite, Hburst latched; Hsize constant.
//  - Pipeline advances only on edges with Hreadyout=1; while 0, Haddr, Htrans, Hwrite,
//    Hwdata are held stable and no counters move.
//  - Addr increments by 4 per accepted addr phase, modulo 2^ADDR_W (0xFFFF_FFFC -> 0).
//    If new addr has bits[9:0]=0 (1KB crossing) Htrans=NONSEQ, else SEQ.
//  - Write: on edge accepting a write addr phase, Hwdata<=wr_data and wr_data_ready=1
//    during that cycle (combinational from state & Hreadyout).
//  - Read: on edge completing a read data phase, rd_data<=Hrdata, rd_valid=1 next cycle.
//  - done/err registered: high for one cycle after the edge completing the final data phase.
//  - ERROR: Hresp=01 with Hreadyout=0 (1st cycle of 2-cycle response) -> Htrans driven
//    IDLE from next edge, no further addr phases or wr_data_ready; when Hreadyout=1
//    ends the response, done=1, err=1 next cycle, state IDLE.
//  - Single-beat latency (no waits): accept E0, addr phase E1, data phase E2, done after E2.
//  - cmd_valid ignored outside IDLE; back-to-back cmd accepted cycle after done.
// TESTING
//  1 write addr 0x8000_0000 len=0 wr_data=0xDEAD_BEEF, Hreadyout=1 -> NONSEQ 1 cycle, Hburst=000,
//    Hwdata=0xDEAD_BEEF next cycle, done=1 err=0 after 3rd edge.
//  2 read 0x8400_0010 len=3, Hrdata=beat idx -> Haddr 10,14,18,1C; Htrans 10,11,11,11; Hburst=001;
//    rd_valid 4 pulses with rd_data 0,1,2,3; done once.
//  3 4-beat write, Hreadyout=0 for 2 cycles during beat 2 -> Haddr/Htrans/Hwdata held,
//    wr_data_ready 4 pulses total, no duplicated beat.
//  4 read 0x8000_03F8 len=3 -> Haddr 3F8,3FC,400,404; Htrans 10,11,10,11.
//  5 4-beat write, Hresp=01 two cycles on beat 1 -> Htrans=00 after first ERROR cycle,
//    only 2 wr_data_ready pulses, done=1 err=1.
//  6 rst=0 mid 8-beat read -> all outputs reset values next edge, no done; cmd_ready=1 after release.

Source files
------------

// File: rtl/ahb_master_initiator_if.sv
// Command, beat-data and AHB-Lite signals shared by the master initiator and
// whatever sits on the other side of it (slave model, bridge, DMA front end).
interface ahb_master_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_data_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] Haddr;
  logic [1:0]        Htrans;
  logic              Hwrite;
  logic [2:0]        Hsize;
  logic [2:0]        Hburst;
  logic [DATA_W-1:0] Hwdata;
  logic              Hreadyout;
  logic [DATA_W-1:0] Hrdata;
  logic [1:0]        Hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data,
    input  Hreadyout, Hrdata, Hresp,
    output cmd_ready, wr_data_ready, rd_data, rd_valid, done, err,
    output Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data,
    output Hreadyout, Hrdata, Hresp,
    input  cmd_ready, wr_data_ready, rd_data, rd_valid, done, err,
    input  Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata
  );
endinterface

// File: rtl/ahb_master_initiator.sv
// AHB-Lite burst master: turns one (addr, dir, len) command into pipelined
// NONSEQ/SEQ word transfers with wait-state, 1KB-boundary and ERROR handling.
module ahb_master_initiator #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input logic                   clk,
  input logic                   rst,
  ahb_master_initiator_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST, S_LAST} state_e;

  localparam logic [1:0] TR_IDLE      = 2'b00;
  localparam logic [1:0] TR_NONSEQ    = 2'b10;
  localparam logic [1:0] TR_SEQ       = 2'b11;
  localparam logic [1:0] RESP_ERROR   = 2'b01;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] SIZE_WORD    = 3'b010;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              err_seen_q, err_seen_d;
  logic [LEN_W-1:0]  addr_left_q, addr_left_d;
  logic              wr_ready;
  logic              data_phase;
  logic              resp_err;
  logic              err_first;
  logic [ADDR_W-1:0] addr_inc;

  // A 1KB crossing has to restart the burst with a NONSEQ transfer.
  function automatic logic [1:0] trans_for(input logic [ADDR_W-1:0] a);
    return (a[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
  endfunction

  assign data_phase = (state_q == S_BURST) || (state_q == S_LAST);
  assign resp_err   = (bus.Hresp == RESP_ERROR);
  assign err_first  = data_phase && !bus.Hreadyout && resp_err;
  assign addr_inc   = haddr_q + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      haddr_q     <= '0;
      htrans_q    <= TR_IDLE;
      hwrite_q    <= 1'b0;
      hburst_q    <= BURST_SINGLE;
      hwdata_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_seen_q  <= 1'b0;
      addr_left_q <= '0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hburst_q    <= hburst_d;
      hwdata_q    <= hwdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_seen_q  <= err_seen_d;
      addr_left_q <= addr_left_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hburst_d    = hburst_q;
    hwdata_d    = hwdata_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_seen_d  = err_seen_q;
    addr_left_d = addr_left_q;
    wr_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d     = S_ADDR;
          haddr_d     = bus.cmd_addr;
          htrans_d    = TR_NONSEQ;
          hwrite_d    = bus.cmd_write;
          hburst_d    = (bus.cmd_len == '0) ? BURST_SINGLE : BURST_INCR;
          addr_left_d = bus.cmd_len;
          err_seen_d  = 1'b0;
        end
      end
      S_ADDR, S_BURST: begin
        // First cycle of an ERROR response cancels the pending address phase.
        if (err_first) begin
          htrans_d    = TR_IDLE;
          err_seen_d  = 1'b1;
          addr_left_d = '0;
          state_d     = S_LAST;
        end else if (bus.Hreadyout) begin
          if (hwrite_q) begin
            wr_ready = 1'b1;
            hwdata_d = bus.wr_data;
          end
          if (state_q == S_BURST) begin
            if (resp_err) begin
              err_seen_d = 1'b1;
            end else if (!hwrite_q) begin
              rd_data_d  = bus.Hrdata;
              rd_valid_d = 1'b1;
            end
          end
          if (addr_left_q == '0) begin
            htrans_d = TR_IDLE;
            state_d  = S_LAST;
          end else begin
            haddr_d     = addr_inc;
            htrans_d    = trans_for(addr_inc);
            addr_left_d = addr_left_q - LEN_W'(1);
            state_d     = S_BURST;
          end
        end
      end
      S_LAST: begin
        if (bus.Hreadyout) begin
          if (!hwrite_q && !resp_err) begin
            rd_data_d  = bus.Hrdata;
            rd_valid_d = 1'b1;
          end
          done_d  = 1'b1;
          err_d   = err_seen_q | resp_err;
          state_d = S_IDLE;
        end else if (err_first) begin
          err_seen_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready     = (state_q == S_IDLE);
  assign bus.wr_data_ready = wr_ready;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.Haddr         = haddr_q;
  assign bus.Htrans        = htrans_q;
  assign bus.Hwrite        = hwrite_q;
  assign bus.Hsize         = SIZE_WORD;
  assign bus.Hburst        = hburst_q;
  assign bus.Hwdata        = hwdata_q;
endmodule

// File: tb/tb_ahb_master_initiator.sv
// Bench for ahb_master_initiator: AHB slave model with programmable waits/errors,
// bus monitor, and a burst-level reference model for directed and random commands.
module tb_ahb_master_initiator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ahb_master_initiator_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) bus ();
  ahb_master_initiator #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic        write;
  } aph_t;

  int checks = 0;
  int fails  = 0;

  // slave configuration for the current command
  int          cfg_wait_beat  = -1;
  int          cfg_wait_cycles = 0;
  int          cfg_err_beat   = -1;
  logic [31:0] cfg_rd_base    = 32'h0;
  logic [31:0] wr_list[$];
  int          wr_idx = 0;

  // monitor records
  aph_t        aph_q[$];
  logic [31:0] wbeat_q[$];
  logic [31:0] rbeat_q[$];
  int wr_pulses = 0, done_cnt = 0, done_cyc = 0, accept_cyc = 0, cyc = 0;
  int hold_viol = 0, err_idle_viol = 0;
  logic last_err = 1'b0;

  // slave/monitor internal state
  bit dp_active = 0, dp_write = 0;
  int dp_idx = 0, beat_ctr = 0, wait_cnt = 0, err_phase = 0;
  bit prev_stall = 0, prev_errfirst = 0;
  logic [31:0] prev_haddr, prev_hwdata;
  logic [1:0]  prev_htrans;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave + monitor: drive slave inputs just after negedge, then observe what
  // the coming rising edge will do.
  initial begin
    bit errfirst_now, completing;
    aph_t r;
    bus.Hreadyout = 1'b1;
    bus.Hresp     = 2'b00;
    bus.Hrdata    = 32'h0;
    bus.wr_data   = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        dp_active = 0; beat_ctr = 0; wait_cnt = 0; err_phase = 0;
        prev_stall = 0; prev_errfirst = 0;
        bus.Hreadyout = 1'b1;
        bus.Hresp     = 2'b00;
        continue;
      end
      bus.wr_data = (wr_idx < wr_list.size()) ? wr_list[wr_idx] : 32'h0;
      if (dp_active) begin
        bus.Hrdata = cfg_rd_base + 32'(dp_idx);
        if (dp_idx == cfg_err_beat && err_phase == 0) begin
          bus.Hreadyout = 1'b0; bus.Hresp = 2'b01; err_phase = 1;
        end else if (dp_idx == cfg_err_beat && err_phase == 1) begin
          bus.Hreadyout = 1'b1; bus.Hresp = 2'b01; err_phase = 2;
        end else if (dp_idx == cfg_wait_beat && wait_cnt < cfg_wait_cycles) begin
          bus.Hreadyout = 1'b0; bus.Hresp = 2'b00; wait_cnt++;
        end else begin
          bus.Hreadyout = 1'b1; bus.Hresp = 2'b00;
        end
      end else begin
        bus.Hreadyout = 1'b1;
        bus.Hresp     = 2'b00;
        bus.Hrdata    = 32'hBAD0_0000;
      end
      #1;
      errfirst_now = dp_active && !bus.Hreadyout && (bus.Hresp == 2'b01);
      if (prev_stall && !prev_errfirst &&
          (bus.Haddr !== prev_haddr || bus.Htrans !== prev_htrans || bus.Hwdata !== prev_hwdata))
        hold_viol++;
      if (prev_errfirst && bus.Htrans !== 2'b00) err_idle_viol++;
      if (bus.wr_data_ready) begin wr_pulses++; wr_idx++; end
      if (bus.rd_valid) rbeat_q.push_back(bus.rd_data);
      if (bus.done) begin done_cnt++; last_err = bus.err; done_cyc = cyc; end
      if (bus.cmd_valid && bus.cmd_ready) accept_cyc = cyc;
      completing = dp_active && bus.Hreadyout;
      if (completing && dp_write && bus.Hresp == 2'b00) wbeat_q.push_back(bus.Hwdata);
      if (completing) dp_active = 0;
      if (bus.Htrans[1] && bus.Hreadyout) begin
        r.addr = bus.Haddr; r.trans = bus.Htrans; r.burst = bus.Hburst; r.write = bus.Hwrite;
        aph_q.push_back(r);
        dp_active = 1; dp_write = bus.Hwrite; dp_idx = beat_ctr; beat_ctr++;
        wait_cnt = 0; err_phase = 0;
      end
      prev_stall    = bus.Htrans[1] && !bus.Hreadyout;
      prev_errfirst = errfirst_now;
      prev_haddr    = bus.Haddr;
      prev_htrans   = bus.Htrans;
      prev_hwdata   = bus.Hwdata;
    end
  end

  task automatic clear_records();
    aph_q.delete(); wbeat_q.delete(); rbeat_q.delete();
    wr_pulses = 0; beat_ctr = 0; hold_viol = 0; err_idle_viol = 0; wr_idx = 0;
  endtask

  // Issue one command, wait for done, then compare against the burst model.
  task automatic run_cmd(input string nm, input bit w, input logic [31:0] a, input int len,
                         input int wbeat, input int wcyc, input int ebeat,
                         input logic [31:0] rbase, input logic [31:0] wseed);
    int n, acc, okb, d0, k, lat;
    logic [31:0] ea;
    logic [1:0]  et;
    @(posedge clk); #2;
    clear_records();
    wr_list.delete();
    for (int i = 0; i <= len; i++) wr_list.push_back(wseed + 32'(i) * 32'h0101_0101);
    cfg_wait_beat = wbeat; cfg_wait_cycles = wcyc; cfg_err_beat = ebeat; cfg_rd_base = rbase;
    d0 = done_cnt;
    for (k = 0; k < 50 && !bus.cmd_ready; k++) begin @(posedge clk); #2; end
    chk({nm, ":cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_len = 4'(len);
    @(posedge clk); #2;
    bus.cmd_valid = 1'b0;
    for (k = 0; k < 300 && done_cnt == d0; k++) begin @(posedge clk); #2; end
    repeat (2) @(posedge clk);
    #2;
    n   = len + 1;
    acc = (ebeat >= 0 && ebeat < n) ? ebeat + 1 : n;
    okb = (ebeat >= 0 && ebeat < n) ? ebeat : n;
    chk({nm, ":done_count"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, ":err"}, 64'(last_err), 64'(acc != n || ebeat == len));
    chk({nm, ":aph_count"}, 64'(aph_q.size()), 64'(acc));
    for (int i = 0; i < acc && i < aph_q.size(); i++) begin
      ea = a + 32'(4 * i);
      et = (i == 0 || ea[9:0] == 10'd0) ? 2'b10 : 2'b11;
      chk($sformatf("%s:haddr[%0d]", nm, i), 64'(aph_q[i].addr), 64'(ea));
      chk($sformatf("%s:htrans[%0d]", nm, i), 64'(aph_q[i].trans), 64'(et));
      chk($sformatf("%s:hburst[%0d]", nm, i), 64'(aph_q[i].burst), (len == 0) ? 64'd0 : 64'd1);
      chk($sformatf("%s:hwrite[%0d]", nm, i), 64'(aph_q[i].write), 64'(w));
    end
    if (w) begin
      chk({nm, ":wr_pulses"}, 64'(wr_pulses), 64'(acc));
      chk({nm, ":wbeat_count"}, 64'(wbeat_q.size()), 64'(okb));
      for (int i = 0; i < okb && i < wbeat_q.size(); i++)
        chk($sformatf("%s:hwdata[%0d]", nm, i), 64'(wbeat_q[i]), 64'(wr_list[i]));
      chk({nm, ":rd_pulses"}, 64'(rbeat_q.size()), 64'd0);
    end else begin
      chk({nm, ":rd_pulses"}, 64'(rbeat_q.size()), 64'(okb));
      for (int i = 0; i < okb && i < rbeat_q.size(); i++)
        chk($sformatf("%s:rd_data[%0d]", nm, i), 64'(rbeat_q[i]), 64'(rbase + 32'(i)));
      chk({nm, ":wr_pulses"}, 64'(wr_pulses), 64'd0);
    end
    chk({nm, ":hold_viol"}, 64'(hold_viol), 64'd0);
    chk({nm, ":err_idle_viol"}, 64'(err_idle_viol), 64'd0);
    if (acc == n && ebeat != len) begin
      lat = n + 2 + ((wbeat >= 0 && wbeat < n) ? wcyc : 0);
      chk({nm, ":latency"}, 64'(done_cyc - accept_cyc), 64'(lat));
    end
  endtask

  initial begin
    int d0, sel, len, wb, wc, eb;
    logic [31:0] r, a;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0; bus.cmd_len = 4'h0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst:htrans", 64'(bus.Htrans), 64'd0);
    chk("rst:haddr", 64'(bus.Haddr), 64'd0);
    chk("rst:hwdata", 64'(bus.Hwdata), 64'd0);
    chk("rst:hburst", 64'(bus.Hburst), 64'd0);
    chk("rst:outs", 64'({bus.rd_valid, bus.done, bus.err, bus.wr_data_ready, bus.Hwrite}), 64'd0);
    chk("rst:hsize", 64'(bus.Hsize), 64'd2);
    rst = 1'b1;

    run_cmd("t1_single_wr", 1'b1, 32'h8000_0000, 0, -1, 0, -1, 32'h0, 32'hDEAD_BEEF);
    run_cmd("t2_rd4", 1'b0, 32'h8400_0010, 3, -1, 0, -1, 32'h0, 32'h0);
    run_cmd("t3_wr4_wait", 1'b1, 32'h8000_0100, 3, 2, 2, -1, 32'h0, 32'h1234_0000);
    run_cmd("t4_rd_1kb", 1'b0, 32'h8000_03F8, 3, -1, 0, -1, 32'h7700_0000, 32'h0);
    run_cmd("t5_wr_err", 1'b1, 32'h8000_0200, 3, -1, 0, 1, 32'h0, 32'hA5A5_0000);
    run_cmd("wrap_rd", 1'b0, 32'hFFFF_FFF8, 3, -1, 0, -1, 32'h0000_1000, 32'h0);

    // Reset in the middle of an 8-beat read.
    @(posedge clk); #2;
    clear_records();
    cfg_wait_beat = -1; cfg_err_beat = -1; cfg_rd_base = 32'h5500_0000;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h9000_0000; bus.cmd_len = 4'd7;
    @(posedge clk); #2;
    bus.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    d0 = done_cnt;
    rst = 1'b0;
    @(posedge clk); #2;
    chk("t6:htrans", 64'(bus.Htrans), 64'd0);
    chk("t6:haddr", 64'(bus.Haddr), 64'd0);
    chk("t6:hwdata", 64'(bus.Hwdata), 64'd0);
    chk("t6:rd_data", 64'(bus.rd_data), 64'd0);
    chk("t6:hburst", 64'(bus.Hburst), 64'd0);
    chk("t6:outs", 64'({bus.rd_valid, bus.done, bus.err, bus.wr_data_ready, bus.Hwrite}), 64'd0);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("t6:cmd_ready", 64'(bus.cmd_ready), 64'd1);
    repeat (20) @(posedge clk);
    #2;
    chk("t6:no_done", 64'(done_cnt - d0), 64'd0);
    chk("t6:htrans_idle", 64'(bus.Htrans), 64'd0);

    for (int it = 0; it < 10; it++) begin
      r   = $urandom();
      sel = $urandom_range(0, 2);
      a   = (sel == 0) ? {r[31:2], 2'b00} : (sel == 1) ? {r[31:10], 10'h3F0} : 32'hFFFF_FFE8;
      len = $urandom_range(0, 15);
      wb  = $urandom_range(0, len);
      wc  = $urandom_range(0, 3);
      eb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      run_cmd($sformatf("rnd%0d", it), 1'($urandom_range(0, 1)), a, len, wb, wc, eb,
              $urandom(), $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end
endmodule
